// File: rtl/tel_exchange.sv
// tel_exchange: single-line telephone exchange controller.
// One shared call channel is arbitrated round-robin among 2**ID_W subscribers.
// Each call runs IDLE -> RING -> TALK (or REJECT) -> IDLE. Every output is a
// flop loaded from the next-state logic, so outputs change on the same edge
// as the state.
module tel_exchange #(
   parameter int ID_W        = 2,
   parameter int RING_CYCLES = 10,
   parameter int HOLD_CYCLES = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [(2**ID_W)-1:0]       req,
   input  logic [(2**ID_W)*ID_W-1:0]  dial,
   input  logic [(2**ID_W)-1:0]       answer,
   input  logic [(2**ID_W)-1:0]       hangup,
   output logic [(2**ID_W)-1:0]       grant,
   output logic [(2**ID_W)-1:0]       ring,
   output logic [(2**ID_W)-1:0]       busy,
   output logic                       line_active,
   output logic [63:0]                statusMsg,
   output logic [15:0]                call_cnt
);

   localparam int N_SUB   = 2**ID_W;
   localparam int CNT_MAX = (RING_CYCLES > HOLD_CYCLES) ? RING_CYCLES : HOLD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [63:0] MSG_IDLE   = "IDLE    ";
   localparam logic [63:0] MSG_RING   = "RINGING ";
   localparam logic [63:0] MSG_TALK   = "TALKING ";
   localparam logic [63:0] MSG_REJECT = "REJECTED";

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RING   = 2'd1,
      S_TALK   = 2'd2,
      S_REJECT = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [ID_W-1:0]  ptr, ptr_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [ID_W-1:0]  caller_id, caller_nx;
   logic [ID_W-1:0]  callee_id, callee_nx;

   logic [N_SUB-1:0] grant_nx, ring_nx, busy_nx;
   logic             line_active_nx;
   logic [63:0]      msg_nx;
   logic [15:0]      call_cnt_nx;

   // Arbiter results for the current cycle
   logic [ID_W-1:0]  win;
   logic [ID_W-1:0]  win_dial;
   logic [ID_W-1:0]  scan_idx;
   logic             found;

   // Decode a subscriber ID into a one-hot subscriber vector
   function automatic logic [N_SUB-1:0] onehot(input logic [ID_W-1:0] id);
      logic [N_SUB-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // Completed-call counter sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Status text shown for a given state
   function automatic logic [63:0] status_text(input state_t s);
      logic [63:0] m;
      case (s)
         S_RING:   m = MSG_RING;
         S_TALK:   m = MSG_TALK;
         S_REJECT: m = MSG_REJECT;
         default:  m = MSG_IDLE;
      endcase
      return m;
   endfunction

   // Round-robin search: first requester at or above ptr, wrapping modulo N_SUB
   always_comb begin
      win      = ptr;
      found    = 1'b0;
      scan_idx = '0;
      for (int i = 0; i < N_SUB; i++) begin
         scan_idx = ptr + i[ID_W-1:0];
         if (!found && req[scan_idx]) begin
            win   = scan_idx;
            found = 1'b1;
         end
      end
   end

   // Destination dialled by the arbitration winner
   always_comb begin
      win_dial = '0;
      for (int i = 0; i < N_SUB; i++) begin
         if (win == i[ID_W-1:0]) begin
            win_dial = dial[i*ID_W +: ID_W];
         end
      end
   end

   // Next-state and next-output logic for the call sequencer
   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      cnt_nx      = cnt;
      caller_nx   = caller_id;
      callee_nx   = callee_id;
      grant_nx    = grant;
      ring_nx     = ring;
      call_cnt_nx = call_cnt;

      case (state)
         S_IDLE: begin
            if (found) begin
               caller_nx = win;
               callee_nx = win_dial;
               ptr_nx    = win + ID_W'(1);
               grant_nx  = onehot(win);
               if (win_dial != win) begin
                  state_nx = S_RING;
                  ring_nx  = onehot(win_dial);
                  cnt_nx   = RING_LOAD;
               end else begin
                  // Dialling yourself is refused outright
                  state_nx = S_REJECT;
                  ring_nx  = '0;
                  cnt_nx   = HOLD_LOAD;
               end
            end
         end

         S_RING: begin
            if (hangup[caller_id]) begin
               state_nx = S_IDLE;
            end else if (hangup[callee_id]) begin
               state_nx = S_REJECT;
               ring_nx  = '0;
               cnt_nx   = HOLD_LOAD;
            end else if (answer[callee_id]) begin
               state_nx = S_TALK;
               ring_nx  = '0;
            end else if (cnt == CNT_ONE) begin
               state_nx = S_REJECT;
               ring_nx  = '0;
               cnt_nx   = HOLD_LOAD;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end

         S_TALK: begin
            if (hangup[caller_id] || hangup[callee_id]) begin
               state_nx    = S_IDLE;
               call_cnt_nx = sat_inc(call_cnt);
            end
         end

         S_REJECT: begin
            // Hangups are deliberately not looked at while the reject is held
            if (cnt == CNT_ONE) begin
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt - CNT_ONE;
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase

      // Entering (or staying in) IDLE always releases the line indications
      if (state_nx == S_IDLE) begin
         grant_nx = '0;
         ring_nx  = '0;
      end

      // Everyone asking while someone else holds the line is told it is busy
      busy_nx        = (state_nx != S_IDLE) ? (req & ~grant_nx) : '0;
      line_active_nx = (state_nx != S_IDLE);
      msg_nx         = status_text(state_nx);
   end

   // State register and registered control outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= '0;
         cnt         <= '0;
         grant       <= '0;
         ring        <= '0;
         busy        <= '0;
         line_active <= 1'b0;
         statusMsg   <= MSG_IDLE;
         call_cnt    <= 16'd0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         cnt         <= cnt_nx;
         grant       <= grant_nx;
         ring        <= ring_nx;
         busy        <= busy_nx;
         line_active <= line_active_nx;
         statusMsg   <= msg_nx;
         call_cnt    <= call_cnt_nx;
      end
   end

   // Caller/callee IDs are only consulted outside IDLE, so they need no reset
   always_ff @(posedge clk) begin
      caller_id <= caller_nx;
      callee_id <= callee_nx;
   end

endmodule

// File: tb/tb_tel_exchange.sv
// Testbench for tel_exchange: table of per-cycle stimulus rows with expected
// outputs; expectations are queued when a row is driven and checked after the
// following clock edge.
module tb_tel_exchange;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, answer, hangup;
   logic [7:0]  dial;
   logic [3:0]  grant, ring, busy;
   logic        line_active;
   logic [63:0] statusMsg;
   logic [15:0] call_cnt;

   tel_exchange #(
      .ID_W(2),
      .RING_CYCLES(10),
      .HOLD_CYCLES(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .dial(dial),
      .answer(answer),
      .hangup(hangup),
      .grant(grant),
      .ring(ring),
      .busy(busy),
      .line_active(line_active),
      .statusMsg(statusMsg),
      .call_cnt(call_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [7:0]  dial;
      logic [3:0]  ans;
      logic [3:0]  hup;
      int          reps;
      logic [3:0]  eg;
      logic [3:0]  er;
      logic [3:0]  eb;
      logic        ea;
      int          em;
      logic [15:0] ec;
   } vec_t;

   typedef struct {
      int          idx;
      logic [3:0]  eg;
      logic [3:0]  er;
      logic [3:0]  eb;
      logic        ea;
      logic [63:0] em;
      logic [15:0] ec;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   localparam int M_IDLE = 0, M_RING = 1, M_TALK = 2, M_REJ = 3;

   function automatic logic [63:0] msg(input int m);
      logic [63:0] s;
      case (m)
         M_RING:  s = "RINGING ";
         M_TALK:  s = "TALKING ";
         M_REJ:   s = "REJECTED";
         default: s = "IDLE    ";
      endcase
      return s;
   endfunction

   task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] dl,
                      input logic [3:0] an, input logic [3:0] hp, input int n,
                      input logic [3:0] eg, input logic [3:0] er, input logic [3:0] eb,
                      input logic ea, input int em, input logic [15:0] ec);
      vec_t v;
      v.rst = r;  v.req = rq; v.dial = dl; v.ans = an; v.hup = hp; v.reps = n;
      v.eg = eg;  v.er = er;  v.eb = eb;   v.ea = ea;  v.em = em;  v.ec = ec;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [63:0] got,
                      input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s row%0d: got %0h required %0h", nm, idx, got, want);
      end
   endtask

   initial begin
      logic [3:0] g, c;
      exp_t       e;

      rst = 1'b1; req = '0; dial = '0; answer = '0; hangup = '0;

      // Reset held two cycles, then one idle cycle
      add(1, 4'h0, 8'h00, 4'h0, 4'h0, 2,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd0);
      add(0, 4'h0, 8'h00, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd0);

      // Round robin with all four requesting; subscriber i dials i+1
      for (int i = 0; i < 5; i++) begin
         g = '0; g[i % 4] = 1'b1;
         c = '0; c[(i + 1) % 4] = 1'b1;
         add(0, 4'hF, 8'h39, 4'h0, 4'h0, 1, g, c,    4'hF & ~g, 1, M_RING, 16'(i));
         add(0, 4'hF, 8'h39, c,    4'h0, 1, g, 4'h0, 4'hF & ~g, 1, M_TALK, 16'(i));
         add(0, 4'hF, 8'h39, 4'h0, g,    1, 4'h0, 4'h0, 4'h0,   0, M_IDLE, 16'(i + 1));
      end

      // Answered call 0 -> 2, with stray answer/hangup from outsiders ignored
      add(0, 4'h1, 8'h3E, 4'h0, 4'h0, 1,  4'h1, 4'h4, 4'h0, 1, M_RING, 16'd5);
      add(0, 4'h1, 8'h3E, 4'h8, 4'h0, 2,  4'h1, 4'h4, 4'h0, 1, M_RING, 16'd5);
      add(0, 4'h1, 8'h3E, 4'h4, 4'h0, 1,  4'h1, 4'h0, 4'h0, 1, M_TALK, 16'd5);
      add(0, 4'h1, 8'h3E, 4'h0, 4'h2, 3,  4'h1, 4'h0, 4'h0, 1, M_TALK, 16'd5);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h4, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd6);

      // Timeout 1 -> 3; dial changes after grant and hangups in REJECT ignored
      add(0, 4'h2, 8'h3E, 4'h0, 4'h0, 1,  4'h2, 4'h8, 4'h0, 1, M_RING, 16'd6);
      add(0, 4'h0, 8'h00, 4'h0, 4'h0, 9,  4'h2, 4'h8, 4'h0, 1, M_RING, 16'd6);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h0, 1,  4'h2, 4'h0, 4'h0, 1, M_REJ,  16'd6);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h2, 4,  4'h2, 4'h0, 4'h0, 1, M_REJ,  16'd6);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd6);

      // Self-dial by 3 (ptr is 2, so 3 beats 1; 1 sees busy)
      add(0, 4'hA, 8'hFE, 4'h0, 4'h0, 1,  4'h8, 4'h0, 4'h2, 1, M_REJ,  16'd6);
      add(0, 4'h0, 8'hFE, 4'h0, 4'h0, 4,  4'h8, 4'h0, 4'h0, 1, M_REJ,  16'd6);
      add(0, 4'h0, 8'hFE, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd6);

      // Caller hangs up during the 2nd ring cycle
      add(0, 4'h1, 8'h3E, 4'h0, 4'h0, 1,  4'h1, 4'h4, 4'h0, 1, M_RING, 16'd6);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h0, 1,  4'h1, 4'h4, 4'h0, 1, M_RING, 16'd6);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h1, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd6);

      // Callee hangs up while ringing -> REJECT for the full hold time
      add(0, 4'h2, 8'h3E, 4'h0, 4'h0, 1,  4'h2, 4'h8, 4'h0, 1, M_RING, 16'd6);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h8, 1,  4'h2, 4'h0, 4'h0, 1, M_REJ,  16'd6);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h0, 4,  4'h2, 4'h0, 4'h0, 1, M_REJ,  16'd6);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd6);

      // Reset aborts a call in TALK; pending requests restart from ptr 0
      add(0, 4'h4, 8'h3E, 4'h0, 4'h0, 1,  4'h4, 4'h8, 4'h0, 1, M_RING, 16'd6);
      add(0, 4'h4, 8'h3E, 4'h8, 4'h0, 1,  4'h4, 4'h0, 4'h0, 1, M_TALK, 16'd6);
      add(0, 4'h4, 8'h3E, 4'h0, 4'h0, 1,  4'h4, 4'h0, 4'h0, 1, M_TALK, 16'd6);
      add(1, 4'h9, 8'h3E, 4'h0, 4'h4, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd0);
      add(1, 4'h9, 8'h3E, 4'h0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd0);
      add(0, 4'h9, 8'h3E, 4'h0, 4'h0, 1,  4'h1, 4'h4, 4'h8, 1, M_RING, 16'd0);
      add(0, 4'h0, 8'h3E, 4'h0, 4'h1, 1,  4'h0, 4'h0, 4'h0, 0, M_IDLE, 16'd0);

      // Apply each row, queue its expectation, check after the next edge
      for (int r = 0; r < vecs.size(); r++) begin
         for (int k = 0; k < vecs[r].reps; k++) begin
            rst    = vecs[r].rst;
            req    = vecs[r].req;
            dial   = vecs[r].dial;
            answer = vecs[r].ans;
            hangup = vecs[r].hup;
            e.idx = r;
            e.eg  = vecs[r].eg;
            e.er  = vecs[r].er;
            e.eb  = vecs[r].eb;
            e.ea  = vecs[r].ea;
            e.em  = msg(vecs[r].em);
            e.ec  = vecs[r].ec;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard row%0d: got empty queue required entry", r);
            end else begin
               e = sb.pop_front();
               chk("grant",       e.idx, 64'(grant),       64'(e.eg));
               chk("ring",        e.idx, 64'(ring),        64'(e.er));
               chk("busy",        e.idx, 64'(busy),        64'(e.eb));
               chk("line_active", e.idx, 64'(line_active), 64'(e.ea));
               chk("statusMsg",   e.idx, statusMsg,        e.em);
               chk("call_cnt",    e.idx, 64'(call_cnt),    64'(e.ec));
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
